// File: rtl/ins_cache_if.sv
// ins_cache_if: fetcher-side and memory-controller-side bus of the instruction cache.
//   fetch_req/fetch_pc       fetcher request and byte address
//   instr_valid/instr_out    instruction returned to the fetcher
//   mem_req/mem_addr         word read request to the memory controller
//   mem_ack/mem_data         one-cycle acknowledge with the returned word
// slave = cache side, master = fetcher + memory controller side.
interface ins_cache_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  instr_valid;
  logic [31:0]           instr_out;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_data;

  modport slave (
    input  fetch_req, fetch_pc, mem_ack, mem_data,
    output instr_valid, instr_out, mem_req, mem_addr
  );

  modport master (
    output fetch_req, fetch_pc, mem_ack, mem_data,
    input  instr_valid, instr_out, mem_req, mem_addr
  );
endinterface

// File: rtl/ins_cache.sv
// ins_cache: direct-mapped, read-only instruction cache.
// Hits are served combinationally in the request cycle; a miss starts a line fill
// that reads the whole line from memory one word at a time, then commits it.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   rdy  global ready; low freezes all state (mem_ack ignored)
//   bus  ins_cache_if.slave: fetch request/response and memory read channel
module ins_cache #(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  ins_cache_if.slave  bus
);
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << OFFSET_BITS;
  localparam int unsigned IDX_LSB  = OFFSET_BITS + 2;
  localparam int unsigned TAG_LSB  = IDX_LSB + INDEX_BITS;
  localparam int unsigned TAG_BITS = ADDR_WIDTH - TAG_LSB;
  localparam int unsigned LINE_W   = ADDR_WIDTH - IDX_LSB;

  typedef enum logic [0:0] {S_IDLE, S_FILL} state_t;

  state_t                 r_state, w_state_nxt;
  logic [LINES-1:0]       r_valid;
  logic [TAG_BITS-1:0]    r_tag  [LINES];
  logic [31:0]            r_data [LINES*WORDS];
  logic [LINE_W-1:0]      r_fill_line, w_fill_line_nxt;
  logic [OFFSET_BITS-1:0] r_cnt, w_cnt_nxt;
  logic                   r_mem_req, w_mem_req_nxt;
  logic [ADDR_WIDTH-1:0]  r_mem_addr, w_mem_addr_nxt;

  logic [INDEX_BITS-1:0]  w_idx;
  logic [OFFSET_BITS-1:0] w_woff;
  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_fill_idx;
  logic [TAG_BITS-1:0]    w_fill_tag;
  logic                   w_hit;
  logic                   w_inval;
  logic                   w_data_we;
  logic                   w_commit;
  logic                   w_unused_ok;

  // Request address split
  assign w_idx  = bus.fetch_pc[TAG_LSB-1:IDX_LSB];
  assign w_woff = bus.fetch_pc[IDX_LSB-1:2];
  assign w_tag  = bus.fetch_pc[ADDR_WIDTH-1:TAG_LSB];

  // Byte offset of the fetch address never selects anything
  assign w_unused_ok = &{1'b0, bus.fetch_pc[1:0]};

  // Latched fill line: low bits are the index, the rest is the tag
  assign w_fill_idx = r_fill_line[INDEX_BITS-1:0];
  assign w_fill_tag = r_fill_line[LINE_W-1:INDEX_BITS];

  // Combinational hit path; suppressed while a fill is in flight
  assign w_hit           = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign bus.instr_valid = bus.fetch_req && w_hit && (r_state == S_IDLE);
  assign bus.instr_out   = bus.instr_valid ? r_data[{w_idx, w_woff}] : 32'h0;

  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;

  // Fill FSM next-state and register updates
  always_comb begin
    w_state_nxt     = r_state;
    w_fill_line_nxt = r_fill_line;
    w_cnt_nxt       = r_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_inval         = 1'b0;
    w_data_we       = 1'b0;
    w_commit        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.fetch_req && !w_hit) begin
          // Old line is dropped up front; read-only, so nothing to write back
          w_fill_line_nxt = bus.fetch_pc[ADDR_WIDTH-1:IDX_LSB];
          w_inval         = 1'b1;
          w_cnt_nxt       = '0;
          w_mem_addr_nxt  = {bus.fetch_pc[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
          w_mem_req_nxt   = 1'b1;
          w_state_nxt     = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.mem_ack) begin
          w_data_we      = 1'b1;
          w_cnt_nxt      = r_cnt + OFFSET_BITS'(1);
          w_mem_addr_nxt = r_mem_addr + ADDR_WIDTH'(4);
          if (r_cnt == OFFSET_BITS'(WORDS - 1)) begin
            w_commit      = 1'b1;
            w_mem_req_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, control registers and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_fill_line <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
    end else if (rdy) begin
      r_state     <= w_state_nxt;
      r_fill_line <= w_fill_line_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      if (w_inval)  r_valid[w_idx]      <= 1'b0;
      if (w_commit) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (w_data_we) r_data[{w_fill_idx, r_cnt}] <= bus.mem_data;
      if (w_commit)  r_tag[w_fill_idx]          <= w_fill_tag;
    end
  end
endmodule

// File: tb/tb_ins_cache.sv
// tb_ins_cache: scoreboard bench for ins_cache with a behavioural memory controller.
module tb_ins_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;

  ins_cache_if #(.ADDR_WIDTH(32)) bus ();

  ins_cache #(
    .INDEX_BITS (6),
    .OFFSET_BITS(2),
    .ADDR_WIDTH (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acks  = 0;
  bit          ack_en  = 1'b1;
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_instr_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Memory image: line 0 holds 0x11,0x22,0x33,0x44; elsewhere an address tag
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) return (32'(a[3:2]) + 32'd1) * 32'h11;
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
  endtask

  // One clock: at the falling edge, answer an outstanding memory request.
  // With rdy low the ack is still pulsed (with junk data) but not consumed.
  task automatic cycle();
    @(negedge clk);
    bus.mem_ack  = 1'b0;
    bus.mem_data = 32'hDEAD_BEEF;
    if (bus.mem_req && ack_en) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexp_req", 32'(bus.mem_req), 32'd0);
      end else begin
        chk("mem_addr", bus.mem_addr, exp_addr_q[0]);
        bus.mem_ack = 1'b1;
        if (rdy) begin
          bus.mem_data = mem_word(bus.mem_addr);
          void'(exp_addr_q.pop_front());
          n_acks++;
        end
      end
    end
  endtask

  task automatic wait_valid(input string tag);
    bit          got = 1'b0;
    logic [31:0] exp;
    for (int n = 0; n < 40 && !got; n++) begin
      cycle();
      got = bus.instr_valid;
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      exp = exp_instr_q.pop_front();
      chk(tag, bus.instr_out, exp);
    end
  endtask

  task automatic wait_acks(input int target, input string tag);
    for (int n = 0; n < 40 && n_acks < target; n++) cycle();
    chk({tag, "_acks"}, 32'(n_acks), 32'(target));
  endtask

  task automatic fetch(input logic [31:0] pc, input bit miss, input string tag);
    logic [31:0] exp;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = pc;
    exp_instr_q.push_back(mem_word(pc & 32'hFFFF_FFFC));
    if (miss) push_line(pc & 32'hFFFF_FFF0);
    #1;
    chk({tag, "_hitnow"}, 32'(bus.instr_valid), miss ? 32'd0 : 32'd1);
    if (!miss) begin
      exp = exp_instr_q.pop_front();
      chk({tag, "_data"}, bus.instr_out, exp);
      cycle();
      chk({tag, "_noreq"}, 32'(bus.mem_req), 32'd0);
    end else begin
      wait_valid(tag);
      chk({tag, "_qempty"}, 32'(exp_addr_q.size()), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    bus.fetch_req = 1'b0;
    bus.fetch_pc  = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_data  = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state, with a request present
    bus.fetch_req = 1'b1;
    #1;
    chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_ivalid",   32'(bus.instr_valid), 32'd0);
    bus.fetch_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rdy = 1'b1;

    // Cold fill of line 0, then same-cycle hit
    fetch(32'h0, 1'b1, "fill0");
    fetch(32'h8, 1'b0, "hit8");

    // Stray acks while idle must not disturb anything
    bus.fetch_req = 1'b0;
    @(negedge clk);
    bus.mem_ack  = 1'b1;
    bus.mem_data = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.mem_ack  = 1'b0;
    chk("idle_ack_noreq", 32'(bus.mem_req), 32'd0);
    fetch(32'h4, 1'b0, "idle_ack_hit4");

    // Conflict on index 0
    fetch(32'h400, 1'b1, "conf400");

    // Refill 0x0; the fetcher rolls back to 0x100 after the second ack
    bus.fetch_pc = 32'h0;
    #1;
    chk("refill0_miss", 32'(bus.instr_valid), 32'd0);
    push_line(32'h0);
    a = n_acks;
    wait_acks(a + 2, "roll");
    bus.fetch_pc = 32'h100;
    push_line(32'h100);
    exp_instr_q.push_back(mem_word(32'h100));
    wait_valid("roll100");
    chk("roll_qempty", 32'(exp_addr_q.size()), 32'd0);
    fetch(32'h4, 1'b0, "roll0_kept");
    fetch(32'h10C, 1'b0, "hit10c");

    // Freeze for three cycles mid-fill with acks pulsed
    bus.fetch_pc = 32'h400;
    push_line(32'h400);
    exp_instr_q.push_back(mem_word(32'h400));
    a = n_acks;
    wait_acks(a + 1, "frz");
    @(posedge clk);
    #1;
    rdy = 1'b0;
    repeat (3) begin
      cycle();
      chk("frz_req", 32'(bus.mem_req), 32'd1);
    end
    @(posedge clk);
    #1;
    rdy = 1'b1;
    wait_valid("frz400");
    chk("frz_qempty", 32'(exp_addr_q.size()), 32'd0);
    fetch(32'h404, 1'b0, "frz404");
    fetch(32'h40C, 1'b0, "frz40c");

    // Asynchronous reset after two acks of a fill
    bus.fetch_pc = 32'h0;
    push_line(32'h0);
    a = n_acks;
    wait_acks(a + 2, "rstfill");
    @(posedge clk);
    #2;
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstfill_req",    32'(bus.mem_req), 32'd0);
    chk("rstfill_ivalid", 32'(bus.instr_valid), 32'd0);
    exp_addr_q.delete();
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h0,   1'b1, "postrst0");
    fetch(32'h100, 1'b1, "postrst100");
    fetch(32'hC,   1'b0, "postrst_hitc");

    bus.fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
